// File: rtl/register_bus_pkg.sv
// register_bus_pkg: shared definitions for the register bus master and its
// address legality checker.
//   - ADDR_W / DATA_W : bus address and data widths
//   - op_e            : request operation codes (READ, WRITE, COPY, reserved)
//   - state_e         : master FSM state encoding
//   - address map bounds and read/write legality helpers
package register_bus_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_COPY  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  // Address map. Addresses 8 and 17 are read-as-zero holes, 30-31 are illegal.
  localparam logic [ADDR_W-1:0] GPR_LO        = 5'd0;
  localparam logic [ADDR_W-1:0] GPR_HI        = 5'd7;
  localparam logic [ADDR_W-1:0] LED_LO        = 5'd9;
  localparam logic [ADDR_W-1:0] LED_HI        = 5'd16;
  localparam logic [ADDR_W-1:0] KNOP_LO       = 5'd18;
  localparam logic [ADDR_W-1:0] KNOP_HI       = 5'd21;
  localparam logic [ADDR_W-1:0] SCHAKELAAR_LO = 5'd22;
  localparam logic [ADDR_W-1:0] SCHAKELAAR_HI = 5'd29;

  // Everything from GPR_LO up to the last switch is readable (holes read 0).
  function automatic logic read_legal(input logic [ADDR_W-1:0] addr);
    return (addr <= SCHAKELAAR_HI);
  endfunction

  // GPRs and LED bits are writable. GPR_LO is 0, so only the upper bound
  // needs a compare for the GPR window.
  function automatic logic write_legal(input logic [ADDR_W-1:0] addr);
    return (addr <= GPR_HI) || ((addr >= LED_LO) && (addr <= LED_HI));
  endfunction

endpackage

// File: rtl/register_bus_addr_check.sv
// register_bus_addr_check: purely combinational legality check of a request.
//   op     : request operation code
//   addr_a : READ/WRITE address, COPY source
//   addr_b : COPY destination (ignored for other ops)
//   legal  : 1 when the request may be issued on the bus
module register_bus_addr_check
  import register_bus_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              legal
);

  // Decode legality per operation; the reserved op is never legal.
  always_comb begin
    legal = 1'b0;
    case (op_e'(op))
      OP_READ:  legal = read_legal(addr_a);
      OP_WRITE: legal = write_legal(addr_a);
      OP_COPY:  legal = read_legal(addr_a) && write_legal(addr_b);
      OP_RSVD:  legal = 1'b0;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/register_bus_master.sv
// register_bus_master: accepts READ / WRITE / COPY requests and runs them as
// bus cycles towards a register controller, returning a one-cycle response.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   req_*               : request handshake (accepted in IDLE when req_valid=1)
//   rsp_*               : completion pulse with read data / error flag
//   chip_enable, write_enable, bus_address, bus_value_out, bus_value_in :
//                         register controller bus
// All bus and response outputs are flops, so no req_* input reaches the bus
// combinationally.
module register_bus_master
  import register_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              chip_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_value_out,
  input  logic [DATA_W-1:0] bus_value_in
);

  // Wait counter reload value: a phase ends when the counter is already 0.
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [2:0]        wait_q, wait_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] bus_address_q, bus_address_d;
  logic [DATA_W-1:0] bus_value_out_q, bus_value_out_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic              req_legal;

  register_bus_addr_check u_addr_check (
    .op     (req_op),
    .addr_a (req_addr_a),
    .addr_b (req_addr_b),
    .legal  (req_legal)
  );

  // Next-state and next-output logic. Bus outputs are computed for the state
  // being entered so that they are valid from the first cycle of RD/WR.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_a_d        = addr_a_q;
    addr_b_d        = addr_b_q;
    data_d          = data_q;
    rd_data_d       = rd_data_q;
    wait_d          = wait_q;
    ce_d            = 1'b0;
    we_d            = 1'b0;
    bus_address_d   = 5'd0;
    bus_value_out_d = bus_value_out_q;
    rsp_valid_d     = 1'b0;
    rsp_data_d      = 16'h0000;
    rsp_error_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = op_e'(req_op);
          addr_a_d = req_addr_a;
          addr_b_d = req_addr_b;
          data_d   = req_data;
          if (!req_legal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else if (op_e'(req_op) == OP_WRITE) begin
            state_d         = WR;
            wait_d          = WAIT_LOAD;
            ce_d            = 1'b1;
            we_d            = 1'b1;
            bus_address_d   = req_addr_a;
            bus_value_out_d = req_data;
          end else begin
            state_d       = RD;
            wait_d        = WAIT_LOAD;
            ce_d          = 1'b1;
            bus_address_d = req_addr_a;
          end
        end else begin
          state_d = IDLE;
        end
      end

      RD: begin
        if (wait_q != 3'd0) begin
          wait_d        = wait_q - 3'd1;
          ce_d          = 1'b1;
          bus_address_d = addr_a_q;
        end else begin
          // Final RD edge: sample the controller's read data.
          rd_data_d = bus_value_in;
          if (op_q == OP_COPY) begin
            state_d         = WR;
            wait_d          = WAIT_LOAD;
            ce_d            = 1'b1;
            we_d            = 1'b1;
            bus_address_d   = addr_b_q;
            bus_value_out_d = bus_value_in;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus_value_in;
          end
        end
      end

      WR: begin
        if (wait_q != 3'd0) begin
          wait_d        = wait_q - 3'd1;
          ce_d          = 1'b1;
          we_d          = 1'b1;
          bus_address_d = (op_q == OP_COPY) ? addr_b_q : addr_a_q;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = (op_q == OP_COPY) ? rd_data_q : 16'h0000;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      op_q            <= OP_READ;
      addr_a_q        <= 5'd0;
      addr_b_q        <= 5'd0;
      data_q          <= 16'h0000;
      rd_data_q       <= 16'h0000;
      wait_q          <= 3'd0;
      ce_q            <= 1'b0;
      we_q            <= 1'b0;
      bus_address_q   <= 5'd0;
      bus_value_out_q <= 16'h0000;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 16'h0000;
      rsp_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      addr_a_q        <= addr_a_d;
      addr_b_q        <= addr_b_d;
      data_q          <= data_d;
      rd_data_q       <= rd_data_d;
      wait_q          <= wait_d;
      ce_q            <= ce_d;
      we_q            <= we_d;
      bus_address_q   <= bus_address_d;
      bus_value_out_q <= bus_value_out_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_error_q     <= rsp_error_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_error_q;
  assign chip_enable   = ce_q;
  assign write_enable  = we_q;
  assign bus_address   = bus_address_q;
  assign bus_value_out = bus_value_out_q;

endmodule

// File: tb/tb_register_bus_master.sv
// tb_register_bus_master: directed, table-driven bench. Instance u_dut0 uses
// zero wait states and talks to a small register-controller model; u_dut1
// uses two wait states and reads an address-derived pattern.
module tb_register_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [4:0]  req_addr_a = 5'd0;
  logic [4:0]  req_addr_b = 5'd0;
  logic [15:0] req_data = 16'h0000;

  logic        rdy0, rv0, re0, ce0, we0;
  logic [15:0] rd0, bo0, bi0;
  logic [4:0]  ba0;
  logic        rdy1, rv1, re1, ce1, we1;
  logic [15:0] rd1, bo1, bi1;
  logic [4:0]  ba1;

  logic        rdy_m, rv_m, re_m, ce_m, we_m;
  logic [15:0] rd_m, bo_m;
  logic [4:0]  ba_m;

  int total = 0;
  int bad = 0;

  // Register controller model state for u_dut0.
  logic        model_clr = 1'b1;
  logic [15:0] gpr [0:7];
  logic [7:0]  led;
  logic [7:0]  sw_bits   = 8'b1010_0101;
  logic [3:0]  knop_bits = 4'b0110;

  always #5 clock = ~clock;

  register_bus_master #(.WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid && !sel), .req_ready(rdy0),
    .req_op(req_op), .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_data(req_data),
    .rsp_valid(rv0), .rsp_data(rd0), .rsp_error(re0), .chip_enable(ce0), .write_enable(we0),
    .bus_address(ba0), .bus_value_out(bo0), .bus_value_in(bi0)
  );

  register_bus_master #(.WAIT_STATES(2)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid && sel), .req_ready(rdy1),
    .req_op(req_op), .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_data(req_data),
    .rsp_valid(rv1), .rsp_data(rd1), .rsp_error(re1), .chip_enable(ce1), .write_enable(we1),
    .bus_address(ba1), .bus_value_out(bo1), .bus_value_in(bi1)
  );

  // Read side of the register controller model.
  always_comb begin
    bi0 = 16'h0000;
    if (ce0 && !we0) begin
      if (ba0 <= 5'd7) bi0 = gpr[ba0[2:0]];
      else if (ba0 >= 5'd9 && ba0 <= 5'd16) bi0 = {15'h0, led[3'(ba0 - 5'd9)]};
      else if (ba0 >= 5'd18 && ba0 <= 5'd21) bi0 = {15'h0, knop_bits[2'(ba0 - 5'd18)]};
      else if (ba0 >= 5'd22 && ba0 <= 5'd29) bi0 = {15'h0, sw_bits[3'(ba0 - 5'd22)]};
      else bi0 = 16'h0000;
    end
    bi1 = (ce1 && !we1) ? ({11'h0, ba1} ^ 16'h5A00) : 16'h0000;
  end

  // Write side of the register controller model.
  always @(posedge clock) begin
    if (model_clr) begin
      for (int i = 0; i < 8; i++) gpr[i] <= 16'h0000;
      led <= 8'h00;
    end else if (ce0 && we0) begin
      if (ba0 <= 5'd7) gpr[ba0[2:0]] <= bo0;
      else if (ba0 >= 5'd9 && ba0 <= 5'd16) led[3'(ba0 - 5'd9)] <= bo0[0];
    end
  end

  // Select which instance the request tasks observe.
  always_comb begin
    if (sel) begin
      rdy_m = rdy1; rv_m = rv1; re_m = re1; ce_m = ce1; we_m = we1; rd_m = rd1; bo_m = bo1; ba_m = ba1;
    end else begin
      rdy_m = rdy0; rv_m = rv0; re_m = re0; ce_m = ce0; we_m = we0; rd_m = rd0; bo_m = bo0; ba_m = ba0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and follow it until rsp_valid (bounded at 40 cycles).
  // lat counts cycles from the accept edge; 1 = first cycle after it.
  task automatic run_req(input logic s, input logic [1:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [15:0] d,
                         output int lat, output logic [15:0] rdat, output logic er,
                         output int ce_n, output logic [4:0] fa,
                         output logic [4:0] wa, output logic [15:0] wv);
    @(negedge clock);
    sel = s; req_op = op; req_addr_a = a; req_addr_b = b; req_data = d; req_valid = 1'b1;
    chk("ready_before_req", {31'h0, rdy_m}, 32'd1);
    @(posedge clock);
    lat = 0; rdat = 16'h0; er = 1'b0; ce_n = 0; fa = 5'd0; wa = 5'd0; wv = 16'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      req_valid = 1'b0;
      if (ce_m) begin
        if (ce_n == 0) fa = ba_m;
        if (we_m) begin wa = ba_m; wv = bo_m; end
        ce_n++;
      end
      if (rv_m) begin
        lat = c; rdat = rd_m; er = re_m;
        break;
      end
    end
  endtask

  typedef struct {
    logic        s;
    logic [1:0]  op;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [15:0] d;
    logic        er;
    logic [15:0] rd;
    int          lat;
    int          ce;
  } vec_t;

  vec_t vt [24];

  initial begin
    int          lat, ce_n;
    logic [15:0] rdat, wv;
    logic        er;
    logic [4:0]  fa, wa;

    //        s     op     a      b      d          er    rd         lat ce
    vt[0]  = '{1'b0, 2'd1, 5'd20, 5'd0,  16'h1234, 1'b1, 16'h0000, 1, 0};
    vt[1]  = '{1'b0, 2'd3, 5'd3,  5'd0,  16'h0000, 1'b1, 16'h0000, 1, 0};
    vt[2]  = '{1'b0, 2'd0, 5'd8,  5'd0,  16'h0000, 1'b0, 16'h0000, 2, 1};
    vt[3]  = '{1'b0, 2'd0, 5'd30, 5'd0,  16'h0000, 1'b1, 16'h0000, 1, 0};
    vt[4]  = '{1'b0, 2'd1, 5'd8,  5'd0,  16'h5555, 1'b1, 16'h0000, 1, 0};
    vt[5]  = '{1'b0, 2'd1, 5'd17, 5'd0,  16'h5555, 1'b1, 16'h0000, 1, 0};
    vt[6]  = '{1'b0, 2'd2, 5'd3,  5'd5,  16'h0000, 1'b0, 16'hBEEF, 3, 2};
    vt[7]  = '{1'b0, 2'd0, 5'd5,  5'd0,  16'h0000, 1'b0, 16'hBEEF, 2, 1};
    vt[8]  = '{1'b0, 2'd2, 5'd22, 5'd18, 16'h0000, 1'b1, 16'h0000, 1, 0};
    vt[9]  = '{1'b0, 2'd2, 5'd31, 5'd0,  16'h0000, 1'b1, 16'h0000, 1, 0};
    vt[10] = '{1'b0, 2'd0, 5'd29, 5'd0,  16'h0000, 1'b0, 16'h0001, 2, 1};
    vt[11] = '{1'b0, 2'd0, 5'd19, 5'd0,  16'h0000, 1'b0, 16'h0001, 2, 1};
    vt[12] = '{1'b0, 2'd1, 5'd16, 5'd0,  16'hFFFF, 1'b0, 16'h0000, 2, 1};
    vt[13] = '{1'b0, 2'd0, 5'd16, 5'd0,  16'h0000, 1'b0, 16'h0001, 2, 1};
    vt[14] = '{1'b0, 2'd1, 5'd7,  5'd0,  16'h1234, 1'b0, 16'h0000, 2, 1};
    vt[15] = '{1'b0, 2'd0, 5'd7,  5'd0,  16'h0000, 1'b0, 16'h1234, 2, 1};
    vt[16] = '{1'b0, 2'd0, 5'd0,  5'd0,  16'h0000, 1'b0, 16'h0000, 2, 1};
    vt[17] = '{1'b1, 2'd0, 5'd5,  5'd0,  16'h0000, 1'b0, 16'h5A05, 4, 3};
    vt[18] = '{1'b1, 2'd1, 5'd2,  5'd0,  16'h1111, 1'b0, 16'h0000, 4, 3};
    vt[19] = '{1'b1, 2'd2, 5'd1,  5'd2,  16'h0000, 1'b0, 16'h5A01, 7, 6};
    vt[20] = '{1'b1, 2'd3, 5'd1,  5'd2,  16'h0000, 1'b1, 16'h0000, 1, 0};
    vt[21] = '{1'b0, 2'd0, 5'd17, 5'd0,  16'h0000, 1'b0, 16'h0000, 2, 1};
    vt[22] = '{1'b0, 2'd0, 5'd21, 5'd0,  16'h0000, 1'b0, 16'h0000, 2, 1};
    vt[23] = '{1'b0, 2'd2, 5'd7,  5'd16, 16'h0000, 1'b0, 16'h1234, 3, 2};

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    chk("rst_ready", {31'h0, rdy0}, 32'd1);
    chk("rst_bus", {6'h0, ce0, we0, ba0, bo0}, 32'd0);
    chk("rst_rsp", {15'h0, rv0, re0, rd0}, 32'd0);
    reset = 1'b0;
    model_clr = 1'b0;

    // WRITE 3 then READ 3, zero wait states.
    run_req(1'b0, 2'd1, 5'd3, 5'd0, 16'hBEEF, lat, rdat, er, ce_n, fa, wa, wv);
    chk("wr3_lat", lat, 32'd2);
    chk("wr3_err", {31'h0, er}, 32'd0);
    chk("wr3_bus", {11'h0, wa, wv}, {11'h0, 5'd3, 16'hBEEF});
    run_req(1'b0, 2'd0, 5'd3, 5'd0, 16'h0000, lat, rdat, er, ce_n, fa, wa, wv);
    chk("rd3_lat", lat, 32'd2);
    chk("rd3_data", {16'h0, rdat}, 32'h0000BEEF);
    chk("rd3_err", {31'h0, er}, 32'd0);
    @(negedge clock);
    chk("idle_hold", {15'h0, ce0, bo0}, 32'h0000BEEF);

    // COPY switch 0 -> LED 0.
    run_req(1'b0, 2'd2, 5'd22, 5'd9, 16'h0000, lat, rdat, er, ce_n, fa, wa, wv);
    chk("cp_rd_addr", {27'h0, fa}, 32'd22);
    chk("cp_wr", {11'h0, wa, wv}, {11'h0, 5'd9, 16'h0001});
    chk("cp_data", {16'h0, rdat}, 32'h00000001);
    chk("cp_lat", lat, 32'd3);
    chk("cp_led0", {31'h0, led[0]}, 32'd1);

    // Table of single requests.
    for (int i = 0; i < 24; i++) begin
      run_req(vt[i].s, vt[i].op, vt[i].a, vt[i].b, vt[i].d, lat, rdat, er, ce_n, fa, wa, wv);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vt[i].er});
      chk($sformatf("v%0d_data", i), {16'h0, rdat}, {16'h0, vt[i].rd});
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_ce", i), ce_n, vt[i].ce);
      if (vt[i].ce > 0) chk($sformatf("v%0d_addr", i), {27'h0, fa}, {27'h0, vt[i].a});
    end

    // req_valid while busy is ignored and not queued.
    @(negedge clock);
    sel = 1'b0; req_op = 2'd2; req_addr_a = 5'd3; req_addr_b = 5'd4; req_valid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c < 3) begin
        req_op = 2'd0; req_addr_a = 5'd0; req_valid = 1'b1;
        chk("busy_ready", {31'h0, rdy0}, 32'd0);
      end else begin
        req_valid = 1'b0;
        chk("busy_rsp", {15'h0, rv0, rd0}, 32'h0001BEEF);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("no_queue", {30'h0, ce0, rv0}, 32'd0);
    end

    // Reset in the second (WR) cycle of a COPY.
    @(negedge clock);
    req_op = 2'd2; req_addr_a = 5'd3; req_addr_b = 5'd6; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("rst_cp_rd", {30'h0, ce0, we0}, 32'd2);
    @(negedge clock);
    chk("rst_cp_wr", {30'h0, ce0, we0}, 32'd3);
    reset = 1'b1;
    #1;
    chk("rst_abort_bus", {6'h0, ce0, we0, ba0, bo0}, 32'd0);
    chk("rst_abort_rsp", {31'h0, rv0}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_quiet", {30'h0, ce0, rv0}, 32'd0);
      if (c == 0) chk("rst_ready_after", {31'h0, rdy0}, 32'd1);
    end
    chk("rst_no_write", {16'h0, gpr[6]}, 32'd0);
    run_req(1'b0, 2'd0, 5'd3, 5'd0, 16'h0000, lat, rdat, er, ce_n, fa, wa, wv);
    chk("post_rst_rd", {16'h0, rdat}, 32'h0000BEEF);
    chk("post_rst_lat", lat, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
